// File: rtl/axi_stream_seq_checker.sv
// axi_stream_seq_checker
// Sink for an AXI-Stream counter source. It checks that every accepted beat is
// the successor of the previous beat, modulo RANGE. It counts transfers and
// sequence errors, checks the source's hold rule under backpressure, and can
// throttle TREADY pseudo-randomly from a 16-bit Galois LFSR.
//
// Ports:
//   clk, rst      single clock; synchronous active-high reset
//   s_tvalid      upstream TVALID
//   s_tready      TREADY (registered)
//   s_tdata       upstream TDATA
//   throttle_en   1: TREADY follows LFSR bit 0, 0: TREADY held high
//   locked        first beat after reset has been accepted
//   err_count     saturating count of sequence mismatches
//   err_pulse     one-cycle strobe per mismatch
//   last_bad      TDATA of the most recent mismatching beat
//   xfer_count    accepted transfers, wraps modulo 2^32
//   proto_err     sticky hold-rule violation flag
module axi_stream_seq_checker #(
  parameter int unsigned DATA_BITS = 32,
  parameter logic [63:0] RANGE     = 64'b1 << DATA_BITS,
  parameter logic [15:0] LFSR_SEED = 16'hACE1,
  parameter int unsigned ERR_BITS  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 s_tvalid,
  output logic                 s_tready,
  input  logic [DATA_BITS-1:0] s_tdata,
  input  logic                 throttle_en,
  output logic                 locked,
  output logic [ERR_BITS-1:0]  err_count,
  output logic                 err_pulse,
  output logic [DATA_BITS-1:0] last_bad,
  output logic [31:0]          xfer_count,
  output logic                 proto_err
);

  localparam int unsigned XFER_BITS = 32;
  localparam logic [DATA_BITS-1:0] LAST_VAL = DATA_BITS'(RANGE - 64'd1);
  localparam logic [15:0] LFSR_MASK = 16'hB400;

  typedef enum logic {
    ST_UNLOCKED = 1'b0,
    ST_LOCKED   = 1'b1
  } state_t;

  state_t                 state_q;
  state_t                 state_d;
  logic [15:0]            lfsr_q;
  logic [15:0]            lfsr_next;
  logic [DATA_BITS-1:0]   expected_q;
  logic [DATA_BITS-1:0]   next_exp;
  logic                   pend_q;
  logic [DATA_BITS-1:0]   pend_data_q;
  logic                   xfer;
  logic                   out_of_range;
  logic                   mismatch;

  // Beat decode and successor of the current beat
  assign xfer         = s_tvalid && s_tready;
  assign out_of_range = 64'(s_tdata) >= RANGE;
  assign next_exp     = (s_tdata == LAST_VAL) ? '0 : s_tdata + DATA_BITS'(1);

  // Right-shifting Galois LFSR step
  assign lfsr_next = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_MASK : 16'h0000);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_UNLOCKED;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: the first accepted beat locks; only reset unlocks
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_UNLOCKED: if (xfer) state_d = ST_LOCKED;
      ST_LOCKED:   state_d = ST_LOCKED;
      default:     state_d = ST_UNLOCKED;
    endcase
  end

  // State-derived decode; the first beat while unlocked is never an error
  always_comb begin
    locked   = 1'b0;
    mismatch = 1'b0;
    case (state_q)
      ST_LOCKED: begin
        locked   = 1'b1;
        mismatch = xfer && ((s_tdata != expected_q) || out_of_range);
      end
      default: begin
        locked   = 1'b0;
        mismatch = 1'b0;
      end
    endcase
  end

  // Throttle, sequence tracking, counters and hold-rule check
  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_q      <= LFSR_SEED;
      s_tready    <= 1'b0;
      expected_q  <= '0;
      err_count   <= '0;
      err_pulse   <= 1'b0;
      last_bad    <= '0;
      xfer_count  <= '0;
      proto_err   <= 1'b0;
      pend_q      <= 1'b0;
      pend_data_q <= '0;
    end else begin
      lfsr_q    <= lfsr_next;
      s_tready  <= !throttle_en || lfsr_q[0];
      err_pulse <= mismatch;

      // Every accepted beat resyncs the expectation, so one glitch is one error
      if (xfer) begin
        xfer_count <= xfer_count + XFER_BITS'(1);
        expected_q <= next_exp;
      end

      if (mismatch) begin
        last_bad <= s_tdata;
        if (err_count != '1) begin
          err_count <= err_count + ERR_BITS'(1);
        end
      end

      // A beat offered but refused must be held unchanged on the next cycle
      pend_q      <= s_tvalid && !s_tready;
      pend_data_q <= s_tdata;
      if (pend_q && (!s_tvalid || (s_tdata != pend_data_q))) begin
        proto_err <= 1'b1;
      end
    end
  end

endmodule

// File: doc/axi_stream_seq_checker.md
# axi_stream_seq_checker

Downstream sink for the AXI-Stream counter source on the Alchitry platform, used during board bring-up and link soak tests. Accepts a stream that must increment by one per transfer and wrap from RANGE-1 to 0, and counts sequence errors and transfers. Checks the source's hold rules under backpressure and can throttle TREADY pseudo-randomly to exercise them. Results are exposed as registered status outputs for the debug/readout logic.

## Interface
- DATA_BITS, 32, width of s_tdata
- RANGE, 64'b1 << DATA_BITS, sequence modulus; the expected successor of RANGE-1 is 0
- LFSR_SEED, 16'hACE1, nonzero reset value of the throttle LFSR
- ERR_BITS, 16, width of err_count (saturating)

- clk  in  1  single clock; every register changes on its rising edge
- rst  in  1  synchronous, active-high reset
- s_tvalid  in  1  upstream TVALID
- s_tready  out  1  TREADY, registered
- s_tdata  in  DATA_BITS  upstream TDATA
- throttle_en  in  1  1 = TREADY follows the LFSR; 0 = TREADY is always high
- locked  out  1  high once the first transfer after reset has been accepted
- err_count  out  ERR_BITS  number of sequence mismatches, saturating at all-ones
- err_pulse  out  1  one-cycle strobe for each mismatch
- last_bad  out  DATA_BITS  s_tdata of the most recent mismatching transfer
- xfer_count  out  32  number of accepted transfers, wraps modulo 2^32
- proto_err  out  1  sticky; set on a hold-rule violation

## Operation
- A transfer is any cycle with s_tvalid && s_tready. Nothing else updates the counters or the expected value.
- TREADY generation:
  - s_tready <= !rst && (!throttle_en || lfsr[0]).
  - The LFSR is a 16-bit Galois LFSR with mask 16'hB400.
  - It loads LFSR_SEED on reset and advances every non-reset cycle, regardless of transfers.
- State machine with two states, UNLOCKED and LOCKED; locked is high exactly when the state is LOCKED.
  - UNLOCKED (reset state): the first transfer sets expected <= next(s_tdata) and moves to LOCKED. That first transfer is never an error.
  - LOCKED, on a transfer, a mismatch is s_tdata != expected, or s_tdata >= RANGE.
  - LOCKED, match: expected <= next(s_tdata).
  - LOCKED, mismatch: err_pulse <= 1, last_bad <= s_tdata, err_count <= err_count+1 unless it is already all-ones, and expected <= next(s_tdata), which resyncs so that one glitch gives one error.
  - The checker never returns to UNLOCKED except through rst.
- next(x) = (x == RANGE-1) ? 0 : x+1. The compare is done at DATA_BITS width; RANGE is compared as a 64-bit constant.
- xfer_count increments on every transfer, including the first one and mismatching ones.
- Hold rule:
  - A pending beat exists when s_tvalid was high last cycle, s_tready was low last cycle, and neither cycle was a reset cycle.
  - On a pending beat, proto_err is set if s_tvalid is now low, or if s_tdata differs from last cycle.
  - proto_err is cleared only by rst.
- Reset mid-stream discards the expected value, the state and all counts. The next accepted beat relocks, whatever its value.

## Timing
- Reset values: s_tready 0, locked 0, err_count 0, err_pulse 0, last_bad 0, xfer_count 0, proto_err 0.
- With throttle_en=0, s_tready first goes high in the first cycle after rst is sampled low.
- All status outputs are registered. They reflect a transfer in cycle N starting in cycle N+1.
  - err_pulse is high for exactly cycle N+1 and is low otherwise, including when consecutive mismatches occur one cycle apart (then it stays high across both).
- Changing throttle_en takes effect on s_tready one cycle later.
- Maximum throughput is one transfer per cycle, with no bubbles when throttle_en=0.
- Simultaneous events:
  - rst has priority over everything.
  - A mismatch with err_count saturated still pulses err_pulse and updates last_bad.

## Test plan
- Reset, throttle off, source sends 0,1,2,…,99 back-to-back
  -> locked=1 the cycle after beat 0, xfer_count=100, err_count=0, proto_err=0.
- DATA_BITS=4, RANGE=10, stream 7,8,9,0,1
  -> no errors.
- DATA_BITS=4, RANGE=10, stream 9,10
  -> err_count=1 and last_bad=10, because 10 ≥ RANGE.
- Stream 5,6,9,10,11
  -> err_count=1, last_bad=9, exactly one err_pulse the cycle after beat 9, expected resyncs.
- Throttle on, source holding tdata under backpressure for 2000 cycles
  -> s_tready low on some cycles and high on some, proto_err=0, err_count=0.
  - Same run, but the source changes tdata from 3 to 4 while s_tready=0 -> proto_err=1, sticky.
- ERR_BITS=2, five mismatches -> err_count=3, five err_pulses. Then assert rst mid-stream and resume at value 40 -> all outputs return to reset values, relock on 40, no error.
